// File: rtl/instr_sequencer_if.sv
// instr_sequencer_if: fetch, decoder and status signals between the sequencer and its environment
interface instr_sequencer_if #(parameter int PC_W = 8);
   logic            run;
   logic            imem_req;
   logic [PC_W-1:0] imem_addr;
   logic            imem_ack;
   logic [15:0]     imem_data;
   logic [3:0]      opcode;
   logic [3:0]      rd;
   logic [3:0]      rs1;
   logic [3:0]      rs2;
   logic            exec_en;
   logic            mem_en;
   logic            wb_en;
   logic            mem_done;
   logic            halted;
   logic            illegal;
   logic [15:0]     retired;
   modport master (
      output run, imem_ack, imem_data, mem_done,
      input  imem_req, imem_addr, opcode, rd, rs1, rs2, exec_en, mem_en, wb_en, halted, illegal, retired
   );
   modport slave (
      input  run, imem_ack, imem_data, mem_done,
      output imem_req, imem_addr, opcode, rd, rs1, rs2, exec_en, mem_en, wb_en, halted, illegal, retired
   );
endinterface

// File: rtl/instr_sequencer.sv
// instr_sequencer: multi-cycle fetch/decode/exec/mem/writeback control sequencer
module instr_sequencer #(
   parameter int              PC_W     = 8,
   parameter logic [PC_W-1:0] RESET_PC = '0
) (
   input logic            clk,
   input logic            rst,
   instr_sequencer_if.slave bus
);
   typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT} state_t;
   state_t          r_state, w_next;
   logic [PC_W-1:0] r_pc;
   logic [15:0]     r_ir, r_retired;
   logic            r_illegal;
   logic [3:0]      w_op;
   logic            w_hlt, w_bad, w_memop, w_store, w_retire;
   logic            w_imem_req, w_exec_en, w_mem_en, w_wb_en, w_halted;
   assign w_op     = r_ir[15:12];
   assign w_hlt    = w_op == 4'hF;
   assign w_bad    = w_op inside {[4'h7:4'hE]};
   assign w_memop  = w_op == 4'h5 || w_op == 4'h6;
   assign w_store  = w_op == 4'h6;
   assign w_retire = r_state == S_WB || (r_state == S_MEM && bus.mem_done && w_store);
   // state register
   always_ff @(posedge clk or posedge rst)
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   // next-state logic; run is sampled only at instruction boundaries
   always_comb begin
      w_next = r_state;
      unique case (r_state)
         S_IDLE:   w_next = bus.run ? S_FETCH : S_IDLE;
         S_FETCH:  w_next = bus.imem_ack ? S_DECODE : S_FETCH;
         S_DECODE: w_next = (w_hlt || w_bad) ? S_HALT : S_EXEC;
         S_EXEC:   w_next = w_memop ? S_MEM : S_WB;
         S_MEM:    w_next = !bus.mem_done ? S_MEM : !w_store ? S_WB : bus.run ? S_FETCH : S_IDLE;
         S_WB:     w_next = bus.run ? S_FETCH : S_IDLE;
         S_HALT:   w_next = S_HALT;
         default:  w_next = S_IDLE;
      endcase
   end
   // phase qualifiers decoded purely from state
   always_comb begin
      w_imem_req = r_state == S_FETCH;
      w_exec_en  = r_state == S_EXEC;
      w_mem_en   = r_state == S_MEM;
      w_wb_en    = r_state == S_WB;
      w_halted   = r_state == S_HALT;
   end
   // PC advance and instruction capture on a completed fetch
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         r_pc <= RESET_PC;
         r_ir <= '0;
      end else if (r_state == S_FETCH && bus.imem_ack) begin
         r_pc <= r_pc + PC_W'(1);
         r_ir <= bus.imem_data;
      end
   // sticky illegal flag and saturating retirement counter
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         r_illegal <= 1'b0;
         r_retired <= '0;
      end else begin
         if (r_state == S_DECODE && w_bad) r_illegal <= 1'b1;
         if (w_retire && r_retired != 16'hFFFF) r_retired <= r_retired + 16'd1;
      end
   assign bus.imem_req  = w_imem_req;
   assign bus.imem_addr = r_pc;
   assign bus.opcode    = r_ir[15:12];
   assign bus.rd        = r_ir[11:8];
   assign bus.rs1       = r_ir[7:4];
   assign bus.rs2       = r_ir[3:0];
   assign bus.exec_en   = w_exec_en;
   assign bus.mem_en    = w_mem_en;
   assign bus.wb_en     = w_wb_en;
   assign bus.halted    = w_halted;
   assign bus.illegal   = r_illegal;
   assign bus.retired   = r_retired;
endmodule
